// File: rtl/rr_grant_ctrl_if.sv
// Request/grant bundle between the requesting units and rr_grant_ctrl.
// master: requester side (drives req/done); slave: the arbiter.
interface rr_grant_ctrl_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grantIdx;
  logic       grantValid;
  logic       timeoutFlag;

  modport master (
    output req,
    output done,
    input  grant,
    input  grantIdx,
    input  grantValid,
    input  timeoutFlag
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grantIdx,
    output grantValid,
    output timeoutFlag
  );
endinterface

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter for 8 requesters: registered one-hot grant plus
// encoded index, held until the owner pulses done or drops its request.
// Optional macro ARB_TIMEOUT_EN: revoke a grant held for MAX_HOLD cycles
// and pulse timeoutFlag; without it timeoutFlag is constant 0.
module rr_grant_ctrl #(
  parameter int unsigned MAX_HOLD = 15
) (
  input logic          clk,
  input logic          rst,
  rr_grant_ctrl_if.slave bus
);

  localparam int unsigned NREQ = 8;
  localparam int unsigned IDXW = 3;
  localparam int unsigned CNTW = 8;

  typedef enum logic {IDLE, BUSY} state_e;

  // Elaboration-time guard on the hold limit.
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_grant_ctrl: MAX_HOLD must be in 1..255");
  end

  state_e            state_q;
  logic [NREQ-1:0]   grant_q;
  logic [IDXW-1:0]   idx_q;
  logic [IDXW-1:0]   ptr_q;
  logic              valid_q;
  logic              tflag_q;
`ifdef ARB_TIMEOUT_EN
  logic [CNTW-1:0]   hold_q;
`endif

  logic [IDXW-1:0]   sel_c;
  logic              any_req_c;
  logic              release_c;

  // Wrap-around priority scan starting at ptr_q; first set request wins.
  always_comb begin
    sel_c     = '0;
    any_req_c = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any_req_c && bus.req[ptr_q + IDXW'(i)]) begin
        sel_c     = ptr_q + IDXW'(i);
        any_req_c = 1'b1;
      end
    end
  end

  // Owner finished (done) or withdrew its request.
  always_comb begin
    release_c = bus.done | ~bus.req[idx_q];
  end

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      tflag_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      tflag_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req_c) begin
            state_q <= BUSY;
            grant_q <= NREQ'(1) << sel_c;
            idx_q   <= sel_c;
            valid_q <= 1'b1;
            ptr_q   <= sel_c + IDXW'(1);
`ifdef ARB_TIMEOUT_EN
            hold_q  <= '0;
`endif
          end
        end
        BUSY: begin
          if (release_c) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
          end
`ifdef ARB_TIMEOUT_EN
          // Normal release above wins; otherwise revoke at the hold limit.
          else if (hold_q == CNTW'(MAX_HOLD - 1)) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            tflag_q <= 1'b1;
          end else begin
            hold_q  <= hold_q + CNTW'(1);
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grantIdx    = idx_q;
  assign bus.grantValid  = valid_q;
  assign bus.timeoutFlag = tflag_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Bench for rr_grant_ctrl: directed scenarios plus random traffic, all
// checked against a behavioural model of owner/priority-pointer/hold time.
module tb_rr_grant_ctrl;

  localparam int unsigned TB_MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst;

  rr_grant_ctrl_if bus_if();

  rr_grant_ctrl #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: owner index (-1 = nobody), next priority, hold time.
  int m_owner;
  int m_ptr;
  int m_hold;
  bit m_tflag;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_tflag = 1'b0;
  endtask

  task automatic model_clock(input logic [7:0] r, input logic d);
    bit rel;
    m_tflag = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < 8; k++) begin
        int c;
        c = (m_ptr + k) % 8;
        if (r[c]) begin
          m_owner = c;
          m_ptr   = (c + 1) % 8;
          m_hold  = 0;
          break;
        end
      end
    end else begin
      rel = d || !r[m_owner];
      if (rel) m_owner = -1;
`ifdef ARB_TIMEOUT_EN
      else if (m_hold == int'(TB_MAX_HOLD) - 1) begin
        m_owner = -1;
        m_tflag = 1'b1;
      end else m_hold++;
`endif
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] eg;
    int         ei;
    eg = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
    ei = (m_owner < 0) ? 0 : m_owner;
    chk({tag, ".grant"},  bus_if.grant, eg);
    chk({tag, ".idx"},    8'(bus_if.grantIdx), 8'(ei));
    chk({tag, ".valid"},  8'(bus_if.grantValid), 8'(m_owner >= 0));
    chk({tag, ".tflag"},  8'(bus_if.timeoutFlag), 8'(m_tflag));
    chk({tag, ".onehot"}, 8'($countones(bus_if.grant) <= 1), 8'd1);
  endtask

  task automatic step(input logic [7:0] r, input logic d, input string tag);
    bus_if.req  = r;
    bus_if.done = d;
    @(posedge clk);
    model_clock(r, d);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus_if.req  = 8'h00;
    bus_if.done = 1'b0;
    #1;
    model_reset();
    check_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    logic       d;

    // Basic grant, done release, then next requester in rotation.
    do_reset();
    step(8'h05, 1'b0, "t1.g0");
    chk("t1.g0.const", bus_if.grant, 8'h01);
    step(8'h05, 1'b1, "t1.rel");
    chk("t1.rel.const", bus_if.grant, 8'h00);
    step(8'h05, 1'b0, "t1.g2");
    chk("t1.g2.const", 8'(bus_if.grantIdx), 8'd2);
    step(8'h05, 1'b1, "t1.rel2");

    // All requesting: index walks 0..7 and wraps, one idle cycle between.
    do_reset();
    step(8'hFF, 1'b0, "wrap.first");
    chk("wrap.first.const", 8'(bus_if.grantIdx), 8'd0);
    for (int i = 1; i <= 8; i++) begin
      step(8'hFF, 1'b1, "wrap.gap");
      chk("wrap.gap.const", 8'(bus_if.grantValid), 8'd0);
      step(8'hFF, 1'b0, "wrap.grant");
      chk("wrap.grant.const", 8'(bus_if.grantIdx), 8'(i % 8));
    end
    step(8'hFF, 1'b1, "wrap.end");

    // Owner withdrawal releases; done while idle changes nothing.
    do_reset();
    step(8'h08, 1'b0, "wd.g3");
    chk("wd.g3.const", 8'(bus_if.grantIdx), 8'd3);
    step(8'h00, 1'b0, "wd.drop");
    chk("wd.drop.const", bus_if.grant, 8'h00);
    step(8'h00, 1'b1, "wd.idle_done1");
    step(8'h00, 1'b1, "wd.idle_done2");
    step(8'h08, 1'b0, "wd.regrant");

    // Asynchronous reset in mid-grant, then pointer back at 0.
    do_reset();
    step(8'h40, 1'b0, "ar.g6");
    chk("ar.g6.const", bus_if.grant, 8'h40);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("ar.async");
    chk("ar.async.const", bus_if.grant, 8'h00);
    #2;
    rst = 1'b0;
    step(8'h40, 1'b0, "ar.after");
    chk("ar.after.const", 8'(bus_if.grantIdx), 8'd6);
    step(8'h40, 1'b1, "ar.rel");

`ifdef ARB_TIMEOUT_EN
    // Hold without done: revoked after MAX_HOLD cycles, then regranted.
    do_reset();
    step(8'h10, 1'b0, "to.g4");
    for (int i = 1; i < int'(TB_MAX_HOLD); i++) step(8'h10, 1'b0, "to.hold");
    chk("to.hold.const", bus_if.grant, 8'h10);
    step(8'h10, 1'b0, "to.revoke");
    chk("to.revoke.const", 8'(bus_if.timeoutFlag), 8'd1);
    step(8'h10, 1'b0, "to.regrant");
    chk("to.regrant.const", 8'(bus_if.grantIdx), 8'd4);
    // done on the timeout cycle is a normal release.
    for (int i = 1; i < int'(TB_MAX_HOLD); i++) step(8'h10, 1'b0, "to.hold2");
    step(8'h10, 1'b1, "to.done_at_limit");
    chk("to.done_at_limit.const", 8'(bus_if.timeoutFlag), 8'd0);
`endif

    // Random traffic with sticky requests so grants last several cycles.
    do_reset();
    r = 8'h00;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 3) r = 8'($urandom);
      else if ($urandom_range(0, 9) == 0) r = 8'h00;
      d = ($urandom_range(0, 4) == 0);
      step(r, d, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_grant_ctrl.md
Name: rr_grant_ctrl

Overview:
- Round-robin arbiter and sequencer that shares one downstream resource among 8 requesters.
- Produces a registered one-hot grant plus its 3-bit encoded index, using the same one-hot to binary mapping as the team's 8-to-3 encoder: bit k maps to index k.
- Holds the grant until the owner signals completion.
- Sits between requesting units and any shared datapath that accepts a single selected source.

Parameters:
- NREQ, 8, number of requesters; fixed at 8 for this revision so grantIdx is 3 bits.
- MAX_HOLD, 15, maximum cycles a grant may be held; used only with ARB_TIMEOUT_EN; range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; bit k high means requester k wants the resource; level-sensitive.
- done  input  1  one-cycle pulse from the current owner: release the resource.
- grant  output  8  registered one-hot grant; all zeros when idle.
- grantIdx  output  3  binary index of the set bit in grant; 3'b000 when idle.
- grantValid  output  1  high while any grant bit is set.
- timeoutFlag  output  1  one-cycle pulse when a grant is forcibly revoked; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, grant=0, grantIdx=0, grantValid=0, timeoutFlag=0, ptr=0, holdCnt=0.
- ptr (3-bit) is the highest-priority index for the next arbitration.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first set bit scanning ptr, ptr+1, ..., ptr+7 mod 8 (wrap-around).
  - At the next edge: grant=onehot(sel), grantIdx=sel, grantValid=1, ptr=sel+1 mod 8 (7 wraps to 0), go to BUSY.
  - Latency from req sampled high to grant visible: 1 cycle.
- BUSY:
  - Grant and grantIdx are stable; other req changes are ignored.
  - Release happens on done==1, or on req[grantIdx]==0 (owner withdrew).
  - On release, at the next edge: grant=0, grantIdx=0, grantValid=0, go to IDLE.
  - Consequence: at least one idle cycle between consecutive grants, with no back-to-back handover.
- done while IDLE: ignored, with no state change.
- done and withdrawal in the same cycle: a single release.
- A new req arriving in the release cycle is arbitrated in the following IDLE cycle.
- Outputs are registered only; there is no combinational path from req to grant.
- Invariant: grant is always zero or one-hot, and grantIdx==encode(grant).

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - holdCnt (8-bit) clears on entering BUSY and increments each BUSY cycle.
  - When holdCnt==MAX_HOLD-1 and no release is pending, the next edge forces release: grant=0, go to IDLE, timeoutFlag=1 for exactly one cycle.
  - A normal release in the same cycle as the timeout takes precedence, so timeoutFlag stays 0.
  - ptr is already advanced past the revoked owner.
- Undefined:
  - No holdCnt logic; the grant is held indefinitely until release.
  - timeoutFlag is constant 0.

Test Plan:
- Reset, then req=8'b0000_0101 → one cycle later grant=8'b0000_0001, grantIdx=0; done pulse → grant=0 next cycle; then grant=8'b0000_0100, grantIdx=2.
- req=8'hFF held, done pulsed once per grant → grantIdx sequence 0,1,2,...,7,0 with exactly one grantValid=0 cycle between grants (wrap check).
- In BUSY with grantIdx=3, drop req[3] without done → grant=0 next cycle; done pulses while IDLE cause no change.
- Assert rst in mid-grant (grant=8'b0100_0000) → all outputs 0 immediately without waiting for a clock edge; after rst release with req=8'h40 → grantIdx=6 (ptr reset to 0).
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=8'h10 held, no done → grant high 4 cycles, then grant=0 and a single-cycle timeoutFlag=1; regrant to index 4 after one idle cycle.
- ARB_TIMEOUT_EN, done on the same cycle as the timeout → normal release, timeoutFlag stays 0.
